// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: mode and handshake-state encodings shared by the immediate-extension unit
package imm_ext_pkg;
  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational (imm, mode) -> OUT_W extended immediate
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data
);
  logic [OUT_W-1:0] sx, zx;
  assign sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zx = {{(OUT_W-IN_W){1'b0}}, imm};
  always_comb
    data = mode == MODE_SIGN  ? sx :
           mode == MODE_ZERO  ? zx :
           mode == MODE_UPPER ? zx << (OUT_W-IN_W) :
                                sx << BR_SHIFT;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender with valid/ready handshake and 2-entry skid buffer
// Optional branch-overflow counter port ovf_count enabled by IMM_EXT_STATS_EN
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_STATS_EN
  , output logic [15:0]    ovf_count
`endif
);
  state_t state, state_nx;
  logic [OUT_W-1:0] ext, skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic in_xfer, out_xfer, load_out, load_skid;
  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT)) u_core (
    .imm(in_imm), .mode(in_mode), .data(ext)
  );
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_valid = state != ST_EMPTY;
  assign load_out  = state == ST_FULL ? out_xfer : in_xfer & (state == ST_EMPTY | out_xfer);
  assign load_skid = state == ST_ONE & in_xfer & ~out_xfer;
  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: state_nx = in_xfer ? ST_ONE : ST_EMPTY;
      ST_ONE:   state_nx = load_skid ? ST_FULL : (out_xfer & ~in_xfer) ? ST_EMPTY : ST_ONE;
      ST_FULL:  state_nx = out_xfer ? ST_ONE : ST_FULL;
      default:  state_nx = ST_EMPTY;
    endcase
  end
  // in_ready comes straight from a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != ST_FULL;
      if (load_out) begin
        out_data <= state == ST_FULL ? skid_data : ext;
        out_tag  <= state == ST_FULL ? skid_tag : in_tag;
      end
      if (load_skid) begin
        skid_data <= ext;
        skid_tag  <= in_tag;
      end
    end
`ifdef IMM_EXT_STATS_EN
  logic [OUT_W+BR_SHIFT-1:0] br_wide;
  logic [BR_SHIFT:0] br_top;
  logic ovf;
  assign br_wide = {{(OUT_W+BR_SHIFT-IN_W){in_imm[IN_W-1]}}, in_imm} << BR_SHIFT;
  assign br_top  = br_wide[OUT_W+BR_SHIFT-1:OUT_W-1];
  assign ovf     = ~(&br_top | ~|br_top);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_count <= '0;
    else if (in_xfer && in_mode == MODE_BRANCH && ovf && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed self-checking bench for imm_extend_pipe (default and swept parameters)
module tb_imm_extend_pipe;
  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0, out_tag;
  logic [31:0] out_data;
  logic b_in_valid = 1'b0, b_out_ready = 1'b1, b_in_ready, b_out_valid;
  logic [11:0] b_in_imm = '0;
  logic [1:0]  b_in_mode = '0;
  logic [4:0]  b_in_tag = '0, b_out_tag;
  logic [23:0] b_out_data;
  int total = 0, bad = 0;
`ifdef IMM_EXT_STATS_EN
  logic [15:0] ovf_count, b_ovf, c_ovf;
  logic c_in_valid = 1'b0, c_in_ready, c_out_valid;
  logic [14:0] c_in_imm = '0;
  logic [1:0]  c_in_mode = '0;
  logic [4:0]  c_out_tag;
  logic [15:0] c_out_data;
`endif
  always #5 clk = ~clk;
  imm_extend_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef IMM_EXT_STATS_EN
    , .ovf_count(ovf_count)
`endif
  );
  imm_extend_pipe #(.IN_W(12), .OUT_W(24), .BR_SHIFT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
    .in_mode(b_in_mode), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
`ifdef IMM_EXT_STATS_EN
    , .ovf_count(b_ovf)
`endif
  );
`ifdef IMM_EXT_STATS_EN
  imm_extend_pipe #(.IN_W(15), .OUT_W(16), .BR_SHIFT(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_imm(c_in_imm),
    .in_mode(c_in_mode), .in_tag(5'd0), .out_valid(c_out_valid), .out_ready(1'b1),
    .out_data(c_out_data), .out_tag(c_out_tag), .ovf_count(c_ovf)
  );
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_modes();
    logic [31:0] exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(i); in_tag = 5'(10 + i);
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL mode%0d_data got=%b/%h want=1/%h", i, out_valid, out_data, exp[i]); end
      total++; if (out_tag !== 5'(10 + i)) begin bad++; $display("FAIL mode%0d_tag got=%h want=%h", i, out_tag, 5'(10 + i)); end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL modes_drain got=%b want=0", out_valid); end
  endtask
  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'd0; in_tag = 5'd1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", in_ready); end
    in_imm = 16'hFFFF; in_mode = 2'd1; in_tag = 5'd2;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
    in_imm = 16'h1234; in_mode = 2'd2; in_tag = 5'd3;
    tick();
    total++; if (in_ready !== 1'b0 || out_data !== 32'h1 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_hold got=%b/%h/%h want=0/00000001/01", in_ready, out_data, out_tag); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h0000FFFF || out_tag !== 5'd2) begin bad++; $display("FAIL bp_drain1 got=%b/%h/%h want=1/0000ffff/02", out_valid, out_data, out_tag); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h12340000 || out_tag !== 5'd3) begin bad++; $display("FAIL bp_drain2 got=%b/%h/%h want=1/12340000/03", out_valid, out_data, out_tag); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] imm [8] = '{16'h0010, 16'hF000, 16'h00FF, 16'h7FFF, 16'hC000, 16'h8000, 16'hABCD, 16'h0003};
    logic [1:0]  md  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [31:0] exp [8] = '{32'h00000010, 32'h0000F000, 32'h00FF0000, 32'h0001FFFC,
                             32'hFFFFC000, 32'hFFFE0000, 32'hABCD0000, 32'h00000003};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = imm[i]; in_mode = md[i]; in_tag = 5'(20 + i);
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_tag !== 5'(20 + i) || in_ready !== 1'b1)
        begin bad++; $display("FAIL b2b%0d got=%b/%h/%h/%b want=1/%h/%h/1", i, out_valid, out_data, out_tag, in_ready, exp[i], 5'(20 + i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0005; in_mode = 2'd0; in_tag = 5'd4;
    tick();
    in_imm = 16'h0006; in_tag = 5'd5;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_full got=%b want=0", in_ready); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin bad++; $display("FAIL rm_async got=%b/%b/%h want=0/1/0", out_valid, in_ready, out_data); end
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0042; in_mode = 2'd1; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h00000042 || out_tag !== 5'd9) begin bad++; $display("FAIL rm_next got=%b/%h/%h want=1/00000042/09", out_valid, out_data, out_tag); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_drain got=%b want=0", out_valid); end
  endtask
  task automatic test_params();
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_imm = 12'h800; b_in_mode = 2'd3; b_in_tag = 5'd7;
    tick();
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 24'hFFF000 || b_out_tag !== 5'd7) begin bad++; $display("FAIL p_branch got=%b/%h/%h want=1/fff000/07", b_out_valid, b_out_data, b_out_tag); end
    b_in_mode = 2'd2; b_in_tag = 5'd8;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 24'h800000 || b_out_tag !== 5'd8) begin bad++; $display("FAIL p_upper got=%b/%h/%h want=1/800000/08", b_out_valid, b_out_data, b_out_tag); end
    tick();
  endtask
`ifdef IMM_EXT_STATS_EN
  task automatic test_stats();
    in_valid = 1'b1; in_imm = 16'h4000; in_mode = 2'd3; in_tag = 5'd1;
    c_in_valid = 1'b1; c_in_imm = 15'h2000; c_in_mode = 2'd3;
    tick();
    in_valid = 1'b0; c_in_valid = 1'b0;
    total++; if (out_data !== 32'h00010000 || ovf_count !== 16'd0) begin bad++; $display("FAIL st_noovf got=%h/%h want=00010000/0000", out_data, ovf_count); end
    total++; if (c_out_data !== 16'h8000 || c_ovf !== 16'd1) begin bad++; $display("FAIL st_ovf got=%h/%h want=8000/0001", c_out_data, c_ovf); end
    tick();
  endtask
`endif
  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_modes();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_params();
`ifdef IMM_EXT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
